// File: rtl/nnacc_requant_pkg.sv
// Shared requantization constants, stage payload types and shift-split helpers.
package nnacc_requant_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PROD_W  = 64;
  localparam int unsigned EXP_W   = 6;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [DATA_W-1:0] INT32_MIN = 32'h8000_0000;
  localparam logic [DATA_W-1:0] INT32_MAX = 32'h7FFF_FFFF;

  // Rounding nudges: +2^30 and 1-2^30.
  localparam logic signed [PROD_W-1:0] NUDGE_POS  = 64'sh0000_0000_4000_0000;
  localparam logic signed [PROD_W-1:0] NUDGE_NEG  = 64'shFFFF_FFFF_C000_0001;
  // 2^31-1, added to negative sums so the arithmetic shift truncates toward zero.
  localparam logic signed [PROD_W-1:0] TRUNC_BIAS = 64'sh0000_0000_7FFF_FFFF;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] mult;
    logic [EXP_W-1:0]  exp;
    logic              last;
  } s1_payload_t;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic             last;
    logic             sat;
    logic             neg;
  } s2_payload_t;

  // Left part of a signed shift: max(shift, 0).
  function automatic logic [SHAMT_W-1:0] shift_left_amt(input logic [EXP_W-1:0] sh);
    return sh[EXP_W-1] ? SHAMT_W'(0) : sh[SHAMT_W-1:0];
  endfunction

  // Right part of a signed shift: max(-shift, 0), with -32 clamped to 31.
  function automatic logic [EXP_W-1:0] shift_right_amt(input logic [EXP_W-1:0] sh);
    logic [EXP_W-1:0] mag;
    mag = -sh;
    if (!sh[EXP_W-1]) return EXP_W'(0);
    if (mag[EXP_W-1]) return EXP_W'(31);
    return mag;
  endfunction

endpackage

// File: rtl/requant_high_mult_if.sv
// Valid/ready stream bundle for requant_high_mult.
//   slave : DUT view (beats in, results out)
//   master: producer/consumer view
interface requant_high_mult_if;
  import nnacc_requant_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] acc_in;
  logic [DATA_W-1:0] mult_in;
  logic [EXP_W-1:0]  shift_in;
  logic              last_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] q_out;
  logic [EXP_W-1:0]  exp_out;
  logic              last_out;

  modport slave (
    input  in_valid, acc_in, mult_in, shift_in, last_in, out_ready,
    output in_ready, out_valid, q_out, exp_out, last_out
  );

  modport master (
    output in_valid, acc_in, mult_in, shift_in, last_in, out_ready,
    input  in_ready, out_valid, q_out, exp_out, last_out
  );
endinterface

// File: rtl/mult32x32_s.sv
// Registered 32x32 signed multiply with load enable.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : capture a*b this cycle
//   a, b       : signed operands
//   p          : registered signed 64-bit product
module mult32x32_s
  import nnacc_requant_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);

  always_ff @(posedge clk) begin
    if (!rst_n)  p <= '0;
    else if (en) p <= PROD_W'(a) * PROD_W'(b);
  end

endmodule

// File: rtl/requant_high_mult.sv
// Pipelined saturating rounding doubling-high multiply for requantization.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : stream slave; acc/mult/shift/last in, q/exp/last out,
//                valid/ready on both sides
// S1 applies the left shift, S2 multiplies, S3 rounds to the high word.
module requant_high_mult
  import nnacc_requant_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  requant_high_mult_if.slave bus
);

  // Stage valid bits: [0]=S1, [1]=S2, [2]=S3 (output register).
  logic [PIPE_STAGES-1:0] vld;
  logic adv1_c, adv2_c, adv3_c, mult_en_c;

  s1_payload_t              s1_q;
  s2_payload_t              s2_q;
  logic signed [PROD_W-1:0] s2_prod;
  logic signed [PROD_W-1:0] sum_c;
  logic signed [PROD_W-1:0] biased_c;
  logic [DATA_W-1:0]        q_c;
  logic                     unused_bits_c;

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv3_c       = !vld[2] || bus.out_ready;
  assign adv2_c       = !vld[1] || adv3_c;
  assign adv1_c       = !vld[0] || adv2_c;
  assign bus.in_ready = adv1_c;
  assign bus.out_valid = vld[2];
  assign mult_en_c    = adv2_c && vld[0];

  // Stage occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (adv1_c) vld[0] <= bus.in_valid;
      if (adv2_c) vld[1] <= vld[0];
      if (adv3_c) vld[2] <= vld[1];
    end
  end

  // S1: left shift (modulo 2^32) and exponent split.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (adv1_c && bus.in_valid) begin
      s1_q.a    <= bus.acc_in << shift_left_amt(bus.shift_in);
      s1_q.mult <= bus.mult_in;
      s1_q.exp  <= shift_right_amt(bus.shift_in);
      s1_q.last <= bus.last_in;
    end
  end

  // S2: product in the sub-module, flags and sideband alongside.
  mult32x32_s u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mult_en_c),
    .a     (s1_q.a),
    .b     (s1_q.mult),
    .p     (s2_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_q <= '0;
    end else if (mult_en_c) begin
      s2_q.exp  <= s1_q.exp;
      s2_q.last <= s1_q.last;
      s2_q.sat  <= (s1_q.a == INT32_MIN) && (s1_q.mult == INT32_MIN);
      s2_q.neg  <= s1_q.a[DATA_W-1] ^ s1_q.mult[DATA_W-1];
    end
  end

  // S3: nudge, divide by 2^31 truncating toward zero, saturate the one overflow.
  always_comb begin
    sum_c    = s2_prod + (s2_q.neg ? NUDGE_NEG : NUDGE_POS);
    biased_c = sum_c[PROD_W-1] ? (sum_c + TRUNC_BIAS) : sum_c;
    q_c      = s2_q.sat ? INT32_MAX : biased_c[DATA_W+30:DATA_W-1];
  end

  assign unused_bits_c = ^{biased_c[PROD_W-1], biased_c[DATA_W-2:0]};

  // Output register; holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.q_out    <= '0;
      bus.exp_out  <= '0;
      bus.last_out <= 1'b0;
    end else if (adv3_c && vld[1]) begin
      bus.q_out    <= q_c;
      bus.exp_out  <= s2_q.exp;
      bus.last_out <= s2_q.last;
    end
  end

endmodule

// File: tb/tb_requant_high_mult.sv
// Self-checking bench for requant_high_mult: directed vectors, a stall
// stream, a randomized stream and a mid-stream reset, against a scoreboard.
module tb_requant_high_mult;
  import nnacc_requant_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [5:0]  e;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  requant_high_mult_if bus ();

  requant_high_mult #(.PIPE_STAGES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: shift split, exact 64-bit product, nudge, truncating divide.
  function automatic void model(input logic [31:0] acc, input logic [31:0] mult,
                                input logic [5:0] sh, output logic [31:0] q,
                                output logic [5:0] e);
    int          s, l, r;
    logic [31:0] a;
    longint      p, t, nudge;
    s = int'($signed(sh));
    l = (s > 0) ? s : 0;
    r = (s < 0) ? -s : 0;
    if (r > 31) r = 31;
    a = acc << l;
    p = longint'($signed(a)) * longint'($signed(mult));
    nudge = (a[31] ^ mult[31]) ? (64'sd1 - (64'sd1 <<< 30)) : (64'sd1 <<< 30);
    t = (p + nudge) / (64'sd1 <<< 31);
    q = t[31:0];
    if (a == 32'h8000_0000 && mult == 32'h8000_0000) q = 32'h7FFF_FFFF;
    e = 6'(r);
  endfunction

  function automatic exp_t expect_of(input logic [31:0] acc, input logic [31:0] mult,
                                     input logic [5:0] sh, input logic last);
    exp_t x;
    model(acc, mult, sh, x.q, x.e);
    x.last = last;
    return x;
  endfunction

  // Output monitor: scoreboard pops on handshake, stall hold checks.
  exp_t        mon_x;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_q;
  logic [5:0]  prev_e;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_q", 64'(bus.q_out), 64'(prev_q));
        chk("hold_exp", 64'(bus.exp_out), 64'(prev_e));
        chk("hold_last", 64'(bus.last_out), 64'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL stale_beat observed=q %0h expected=no beat", bus.q_out);
        end
        if (sb.size() != 0) begin
          mon_x = sb.pop_front();
          chk("q_out", 64'(bus.q_out), 64'(mon_x.q));
          chk("exp_out", 64'(bus.exp_out), 64'(mon_x.e));
          chk("last_out", 64'(bus.last_out), 64'(mon_x.last));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_q     = bus.q_out;
      prev_e     = bus.exp_out;
      prev_last  = bus.last_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for acceptance; returns 1ns after the accept edge.
  task automatic send(input logic [31:0] acc, input logic [31:0] mult,
                      input logic [5:0] sh, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.acc_in   = acc;
    bus.mult_in  = mult;
    bus.shift_in = sh;
    bus.last_in  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", 64'(bus.in_ready), 64'd1);
    if (bus.in_ready) sb.push_back(expect_of(acc, mult, sh, last));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Single beat into an empty pipe: latency plus explicit expected result.
  task automatic directed(input string tag, input logic [31:0] acc, input logic [31:0] mult,
                          input logic [5:0] sh, input logic [31:0] q_exp, input logic [5:0] e_exp);
    send(acc, mult, sh, 1'b0);
    chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    tick();
    chk({tag, "_lat2"}, 64'(bus.out_valid), 64'd0);
    tick();
    chk({tag, "_lat3"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_q"}, 64'(bus.q_out), 64'(q_exp));
    chk({tag, "_exp"}, 64'(bus.exp_out), 64'(e_exp));
    repeat (2) tick();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_q"}, 64'(bus.q_out), 64'd0);
    chk({tag, "_exp"}, 64'(bus.exp_out), 64'd0);
    chk({tag, "_last"}, 64'(bus.last_out), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      n++;
      tick();
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [31:0] s_acc [8];
  logic [31:0] s_mult[8];
  logic [5:0]  s_sh  [8];
  logic        s_last[8];

  initial begin
    int idx;
    logic pend;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.acc_in    = '0;
    bus.mult_in   = '0;
    bus.shift_in  = '0;
    bus.last_in   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    check_reset_state("rst");
    tick();

    // Directed vectors
    directed("pos", 32'd100, 32'h4000_0000, 6'd0, 32'd50, 6'd0);
    directed("neg", -32'sd100, 32'h4000_0000, 6'd0, -32'sd50, 6'd0);
    directed("sat", 32'h8000_0000, 32'h8000_0000, 6'd0, 32'h7FFF_FFFF, 6'd0);
    directed("shl2", 32'd3, 32'h7FFF_FFFF, 6'd2, 32'd12, 6'd0);
    directed("shr5", 32'd3, 32'h7FFF_FFFF, 6'h3B, 32'd3, 6'd5);
    directed("shr32", 32'd3, 32'h7FFF_FFFF, 6'h20, 32'd3, 6'd31);

    // Stall stream: 8 beats, out_ready low for cycles 4..8
    for (int i = 0; i < 8; i++) begin
      s_acc[i]  = $urandom;
      s_mult[i] = $urandom;
      s_sh[i]   = 6'($urandom);
      s_last[i] = 1'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 60 && (idx < 8 || sb.size() != 0); c++) begin
      bus.out_ready = !(c >= 4 && c <= 8);
      if (idx < 8) begin
        bus.in_valid = 1'b1;
        bus.acc_in   = s_acc[idx];
        bus.mult_in  = s_mult[idx];
        bus.shift_in = s_sh[idx];
        bus.last_in  = s_last[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 4 && c <= 8) chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(expect_of(s_acc[idx], s_mult[idx], s_sh[idx], s_last[idx]));
        idx++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stall_all_sent", 64'(idx), 64'd8);
    drain();

    // Randomized stream with random backpressure
    pend = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend         = 1'b1;
        bus.in_valid = 1'b1;
        bus.acc_in   = $urandom;
        bus.mult_in  = $urandom;
        if ($urandom_range(0, 7) == 0) begin
          bus.acc_in  = 32'h8000_0000;
          bus.mult_in = 32'h8000_0000;
        end
        bus.shift_in = 6'($urandom);
        bus.last_in  = 1'($urandom);
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(expect_of(bus.acc_in, bus.mult_in, bus.shift_in, bus.last_in));
        pend = 1'b0;
      end
      tick();
      if (!pend) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    drain();

    // Mid-stream reset with three beats held
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom | 32'h0000_0100, 32'h4000_0000, 6'd1, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    check_reset_state("midrst");
    bus.out_ready = 1'b1;
    repeat (8) tick();
    send(32'd100, 32'h4000_0000, 6'd0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/requant_high_mult.md
# requant_high_mult

Pipelined saturating rounding doubling-high multiply for NN-accelerator requantization. Takes a 32-bit accumulator plus per-beat multiplier and signed shift; applies the left part of the shift, multiplies, and outputs the rounded high word with the right-shift exponent. Sits directly upstream of the rounding divide-by-power-of-two stage, which consumes `q_out` as dividend and `exp_out` as exponent. Streams at one beat per cycle with valid/ready backpressure.

## Interface
- `PIPE_STAGES`, 3, fixed pipeline depth; only 3 is supported.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  stage accepts beat this cycle.
- `acc_in`  in  32  signed accumulator.
- `mult_in`  in  32  signed Q31 multiplier.
- `shift_in`  in  6  signed shift, two's complement, -32..+31.
- `last_in`  in  1  sideband, passed through unchanged.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `q_out`  out  32  signed high-multiply result.
- `exp_out`  out  6  unsigned right-shift exponent, 0..31.
- `last_out`  out  1  delayed `last_in`.

## Operation
- Shift split: left = max(shift,0); right = max(-shift,0), with -32 clamped to 31; `exp_out` = right.
- S1: a = acc_in << left, truncated modulo 2^32 with no saturation. Register a, mult, right, last.
- S2: p = a * mult as a signed 64-bit product. Register p, a flag `sat` = (a == 0x80000000 && mult == 0x80000000), and the sign flag = sign(a) XOR sign(mult).
- S3: nudge = 2^30 if sign flag is 0, else 1 - 2^30. r = (p + nudge) / 2^31 with truncation toward zero: add 2^31-1 before the arithmetic shift when p+nudge is negative. Take the low 32 bits. If `sat`, q = 0x7FFFFFFF.
- Pipeline control: each stage has a valid bit and advances when the next stage is empty or advancing.
  - S3 advances when !out_valid || out_ready.
  - in_ready = S1 empty || S1 advancing.
  - No combinational path from in_valid to out_valid.
- A beat transfers on valid && ready at each boundary. Order is preserved, and no beat is dropped or duplicated.
- While out_valid && !out_ready, out data is held stable.

## Timing
- Latency: 3 cycles from input handshake to out_valid with no backpressure.
- Throughput: 1 beat/cycle.
- Full stall: with out_ready low, 3 beats are held and in_ready drops in the cycle after S1 fills. When out_ready rises, in_ready rises in the same cycle.
- Reset, including mid-stream: on the edge with rst_n=0, all stage valid bits clear. Next cycle: out_valid=0, in_ready=1, q_out=0, exp_out=0, last_out=0. In-flight beats are discarded.
- Simultaneous in/out handshake on a full pipeline: both transfer and occupancy is unchanged.

## Structure
- Shared package `nnacc_requant_pkg`:
  - INT32_MIN, INT32_MAX.
  - NUDGE_POS = 2^30 and NUDGE_NEG = 1-2^30.
  - EXP_W = 6, the exponent width shared with the divider.
- One sub-module, `mult32x32_s`: registered 32x32 signed multiply (S2) with enable input, so the team can swap in a DSP-mapped or multi-cycle multiplier.

## Test plan
- acc=100, mult=0x40000000, shift=0 -> q_out=50, exp_out=0, valid exactly 3 cycles after accept.
- acc=-100, mult=0x40000000, shift=0 -> q_out=-50, showing symmetric rounding with truncation toward zero.
- acc=0x80000000, mult=0x80000000, shift=0 -> q_out=0x7FFFFFFF (saturation).
- acc=3, mult=0x7FFFFFFF, shift=+2 -> q_out=12, exp_out=0. acc=3, same mult, shift=-5 -> q_out=3, exp_out=5. shift=-32 -> exp_out=31.
- Stream 8 beats with out_ready low for cycles 4-8 -> in_ready low while 3 held. All 8 beats emerge in order with matching last_out. Held q_out is stable during the stall.
- rst_n low for one cycle with 3 beats in flight -> out_valid=0, in_ready=1 next cycle. No stale beat appears afterward.
